// File: rtl/adc_spi_rd.sv
`timescale 1ns/1ps
// adc_spi_rd: SPI master that clocks one FRAME_BITS-long conversion out of an ADC and keeps the last 12 bits.
// Optional macro ADC_AVG4_EN: one request runs four frames and reports the truncated mean of the samples.
module adc_spi_rd #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_go,
    output logic        adc_done,
    output logic        adc_busy,
    output logic [11:0] adc_data,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    input  logic        adc_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] HALF_LD  = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [5:0]            bit_q, bit_d;
    logic                  half_q, half_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [11:0]           data_q, data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  start_s;

`ifdef ADC_AVG4_EN
    logic [13:0]           acc_q, acc_d;
    logic [13:0]           sum_s;
    logic [1:0]            frame_q, frame_d;
    logic                  avg_run_q, avg_run_d;

    // Frames 2..4 of an averaging run start on their own after the gap cycle.
    assign start_s = adc_go | avg_run_q;
`else
    assign start_s = adc_go;
`endif

    // Next-state, counters, shift register and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef ADC_AVG4_EN
        acc_d     = acc_q;
        frame_d   = frame_q;
        avg_run_d = avg_run_q;
        sum_s     = acc_q + {2'b00, shreg_q[11:0]};
`endif
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = SETUP;
                    cnt_d   = HALF_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = SHIFT;
                    cnt_d   = HALF_LD;
                    half_d  = 1'b0;
                    bit_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = HALF_LD;
                    if (!half_q) begin
                        // This edge raises SCLK, so it is also the sampling edge.
                        half_d  = 1'b1;
                        shreg_d = (shreg_q << 1) | {{(FRAME_BITS-1){1'b0}}, adc_dout};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        half_d  = 1'b0;
                    end else begin
                        half_d = 1'b0;
                        bit_d  = bit_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                bit_d   = 6'd0;
`ifdef ADC_AVG4_EN
                if (frame_q == 2'd3) begin
                    data_d    = 12'(sum_s >> 2);
                    done_d    = 1'b1;
                    acc_d     = 14'd0;
                    frame_d   = 2'd0;
                    avg_run_d = 1'b0;
                end else begin
                    acc_d     = sum_s;
                    frame_d   = frame_q + 2'd1;
                    avg_run_d = 1'b1;
                end
`else
                data_d = shreg_q[11:0];
                done_d = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sclk_d = ~((state_d == SHIFT) & ~half_d);
        cs_n_d = ~((state_d == SETUP) | (state_d == SHIFT));
`ifdef ADC_AVG4_EN
        busy_d = (state_d != IDLE) | avg_run_d;
`else
        busy_d = (state_d != IDLE);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 6'd0;
            half_q    <= 1'b0;
            shreg_q   <= {FRAME_BITS{1'b0}};
            data_q    <= 12'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b1;
            cs_n_q    <= 1'b1;
`ifdef ADC_AVG4_EN
            acc_q     <= 14'd0;
            frame_q   <= 2'd0;
            avg_run_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
`ifdef ADC_AVG4_EN
            acc_q     <= acc_d;
            frame_q   <= frame_d;
            avg_run_q <= avg_run_d;
`endif
        end
    end

    assign adc_done = done_q;
    assign adc_busy = busy_q;
    assign adc_data = data_q;
    assign adc_sclk = sclk_q;
    assign adc_cs_n = cs_n_q;

endmodule

// File: tb/tb_adc_spi_rd.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for adc_spi_rd: two instances (default and CLK_DIV=1/FRAME_BITS=12) driven by a behavioural ADC.
module tb_adc_spi_rd;

    localparam int CD0 = 2;
    localparam int FB0 = 16;
    localparam int CD1 = 1;
    localparam int FB1 = 12;
    localparam int LAT0 = (2*FB0+2)*CD0+1;
    localparam int LAT1 = (2*FB1+2)*CD1+1;
`ifdef ADC_AVG4_EN
    localparam int NW = 4;
    localparam int RST_AT = 100;
`else
    localparam int NW = 1;
    localparam int RST_AT = 30;
`endif

    typedef struct {
        logic [11:0] data;
        longint      when;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go0, go1;
    logic        done0, busy0, sclk0, cs0_n, dout0;
    logic        done1, busy1, sclk1, cs1_n, dout1;
    logic [11:0] data0, data1;

    longint      cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [31:0] wq0[$];
    logic [31:0] wq1[$];
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] word0, word1;
    int          bitp0, bitp1;
    int          rise0, rise1;
    exp_t        it0, it1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_rd #(.CLK_DIV(CD0), .FRAME_BITS(FB0)) u0 (
        .clk(clk), .rst_n(rst_n), .adc_go(go0), .adc_done(done0), .adc_busy(busy0),
        .adc_data(data0), .adc_sclk(sclk0), .adc_cs_n(cs0_n), .adc_dout(dout0)
    );

    adc_spi_rd #(.CLK_DIV(CD1), .FRAME_BITS(FB1)) u1 (
        .clk(clk), .rst_n(rst_n), .adc_go(go1), .adc_done(done1), .adc_busy(busy1),
        .adc_data(data1), .adc_sclk(sclk1), .adc_cs_n(cs1_n), .adc_dout(dout1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ADC: a new word per CS falling edge, next bit (MSB first) launched on each SCLK fall.
    initial begin
        dout0 = 1'b0;
        dout1 = 1'b0;
    end

    always @(negedge cs0_n) begin
        if (wq0.size() == 0) begin
            chk("adc0_unexpected_frame", 64'd1, 64'd0);
            word0 = 32'h0;
        end else begin
            word0 = wq0.pop_front();
        end
        bitp0 = FB0 - 1;
        rise0 = 0;
    end

    always @(negedge sclk0) begin
        if (cs0_n === 1'b0 && bitp0 >= 0) begin
            dout0 = word0[bitp0];
            bitp0--;
        end
    end

    always @(posedge sclk0) if (cs0_n === 1'b0) rise0++;

    always @(posedge cs0_n) if (rst_n === 1'b1) chk("sclk0_rises", 64'(rise0), 64'(FB0));

    always @(negedge cs1_n) begin
        if (wq1.size() == 0) begin
            chk("adc1_unexpected_frame", 64'd1, 64'd0);
            word1 = 32'h0;
        end else begin
            word1 = wq1.pop_front();
        end
        bitp1 = FB1 - 1;
        rise1 = 0;
    end

    always @(negedge sclk1) begin
        if (cs1_n === 1'b0 && bitp1 >= 0) begin
            dout1 = word1[bitp1];
            bitp1--;
        end
    end

    always @(posedge sclk1) if (cs1_n === 1'b0) rise1++;

    always @(posedge cs1_n) if (rst_n === 1'b1) chk("sclk1_rises", 64'(rise1), 64'(FB1));

    // Monitors: every adc_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done0 === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("done0_spurious", 64'd1, 64'd0);
            end else begin
                it0 = sb0.pop_front();
                chk("done0_data", 64'(data0), 64'(it0.data));
                chk("done0_cycle", 64'(cyc), 64'(it0.when));
            end
        end
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("done1_spurious", 64'd1, 64'd0);
            end else begin
                it1 = sb1.pop_front();
                chk("done1_data", 64'(data1), 64'(it1.data));
                chk("done1_cycle", 64'(cyc), 64'(it1.when));
            end
        end
    end

    // One request: NW words to the ADC, expected mean and completion cycle to the scoreboard.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] f, output longint e);
        logic [31:0] w[4];
        int          sum;
        exp_t        item;
        w   = '{a, b, c, f};
        sum = 0;
        for (int i = 0; i < NW; i++) begin
            sum += int'(w[i][11:0]);
            if (d == 0) wq0.push_back(w[i]);
            else        wq1.push_back(w[i]);
        end
        @(negedge clk);
        e         = cyc + 1;
        item.data = 12'(sum / NW);
        item.when = e + NW * (((d == 0) ? LAT0 : LAT1) + 1) - 1;
        if (d == 0) begin
            sb0.push_back(item);
            go0 = 1'b1;
        end else begin
            sb1.push_back(item);
            go1 = 1'b1;
        end
        @(negedge clk);
        go0 = 1'b0;
        go1 = 1'b0;
    endtask

    task automatic drain(input int d);
        int k;
        int left;
        k    = 0;
        left = (d == 0) ? sb0.size() : sb1.size();
        while (left != 0 && k < 2000) begin
            @(negedge clk);
            k++;
            left = (d == 0) ? sb0.size() : sb1.size();
        end
        chk("drain_timeout", 64'(left), 64'd0);
        if (d == 0) sb0.delete();
        else        sb1.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint      e;
        logic [31:0] w;
        exp_t        item;

        rst_n = 1'b0;
        go0   = 1'b0;
        go1   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs0_n), 64'd1);
        chk("rst_sclk", 64'(sclk0), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_data", 64'(data0), 64'd0);
        chk("rst_cs1_n", 64'(cs1_n), 64'd1);
        chk("rst_data1", 64'(data1), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy0), 64'd0);
        chk("idle_cs_n", 64'(cs0_n), 64'd1);

`ifdef ADC_AVG4_EN
        issue(0, 32'h100, 32'h101, 32'h102, 32'h104, e);
`else
        issue(0, 32'h0000_0A5C, 32'h0, 32'h0, 32'h0, e);
`endif
        drain(0);

        // Requests during a conversion must be dropped.
        issue(0, $urandom(), $urandom(), $urandom(), $urandom(), e);
        while (cyc < e + 5) @(negedge clk);
        go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
        while (cyc < e + 40) @(negedge clk);
        go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
        drain(0);
        repeat (120) @(negedge clk);

`ifndef ADC_AVG4_EN
        // adc_go held high: one IDLE cycle between frames.
        @(negedge clk);
        e = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            w = $urandom();
            w[11:0] = (k == 0) ? 12'h001 : ((k == 1) ? 12'hFFF : 12'h800);
            wq0.push_back(w);
            item.data = w[11:0];
            item.when = e + LAT0 + k * (LAT0 + 1);
            sb0.push_back(item);
        end
        go0 = 1'b1;
        while (cyc < e + 150) @(negedge clk);
        go0 = 1'b0;
        drain(0);
        repeat (100) @(negedge clk);
`endif

        for (int k = 0; k < 4; k++) begin
            issue(0, $urandom(), $urandom(), $urandom(), $urandom(), e);
            drain(0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Reset in the middle of a conversion.
        issue(0, $urandom(), $urandom(), $urandom(), $urandom(), e);
        while (cyc < e + RST_AT - 1) @(negedge clk);
        rst_n = 1'b0;
        sb0.delete();
        wq0.delete();
        @(negedge clk);
        chk("midrst_cs_n", 64'(cs0_n), 64'd1);
        chk("midrst_sclk", 64'(sclk0), 64'd1);
        chk("midrst_data", 64'(data0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_done", 64'(done0), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst_cs_n", 64'(cs0_n), 64'd1);
        chk("postrst_busy", 64'(busy0), 64'd0);
        issue(0, $urandom(), $urandom(), $urandom(), $urandom(), e);
        drain(0);

`ifdef ADC_AVG4_EN
        issue(1, 32'h3C3, 32'h3C4, 32'h3C5, 32'h3C7, e);
`else
        issue(1, 32'h3C3, 32'h0, 32'h0, 32'h0, e);
`endif
        drain(1);
        for (int k = 0; k < 3; k++) begin
            issue(1, $urandom(), $urandom(), $urandom(), $urandom(), e);
            drain(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
